// File: rtl/d_axi_sram_responder_if.sv
// d_axi_sram_responder_if: AXI4-subset data-side bus between the data arbiter (master) and the SRAM responder (slave)
interface d_axi_sram_responder_if;
  logic [31:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic arvalid, arready;
  logic [31:0] rdata;
  logic rlast, rvalid, rready;
  logic [31:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic awvalid, awready;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic wlast, wvalid, wready;
  logic bvalid, bready;
  modport master (
    output araddr, arlen, arsize, arvalid, rready, awaddr, awlen, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input arready, rdata, rlast, rvalid, awready, wready, bvalid
  );
  modport slave (
    input araddr, arlen, arsize, arvalid, rready, awaddr, awlen, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output arready, rdata, rlast, rvalid, awready, wready, bvalid
  );
endinterface

// File: rtl/d_axi_sram_responder.sv
// d_axi_sram_responder: single-outstanding AXI4-subset SRAM responder; define AXI_SLV_CHECK_EN for a sticky protocol checker on proto_err
module d_axi_sram_responder #(
  parameter int MEM_AW = 12
) (
  input  logic clk,
  input  logic rst,
  d_axi_sram_responder_if.slave bus,
  output logic proto_err
);
  typedef enum logic [1:0] {IDLE, RD, WR, WB} state_t;
  state_t state, nxt;
  logic [31:0] mem [2**MEM_AW];
  logic [MEM_AW-1:0] idx, ar_idx, aw_idx;
  logic [7:0] cnt, len;
  logic idle, at_last, ar_hs, aw_hs, r_hs, w_hs, b_hs;
  logic unused;
  assign ar_idx = bus.araddr[MEM_AW+1:2];
  assign aw_idx = bus.awaddr[MEM_AW+1:2];
  assign at_last = cnt == len;
  assign ar_hs = bus.arvalid & bus.arready;
  assign aw_hs = bus.awvalid & bus.awready;
  assign r_hs = bus.rvalid & bus.rready;
  assign w_hs = bus.wvalid & bus.wready;
  assign b_hs = bus.bvalid & bus.bready;
  assign unused = ^{bus.araddr[31:MEM_AW+2], bus.araddr[1:0], bus.awaddr[31:MEM_AW+2], bus.awaddr[1:0], bus.arsize, bus.awsize};
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = aw_hs ? WR : ar_hs ? RD : IDLE;
      RD:   nxt = (r_hs && at_last) ? IDLE : RD;
      WR:   nxt = (w_hs && at_last) ? WB : WR;
      WB:   nxt = b_hs ? IDLE : WB;
      default: nxt = IDLE;
    endcase
  end
  // Address readies are held low while rst is high so nothing is accepted mid-reset.
  always_comb begin
    idle = ~rst & (state == IDLE);
    bus.awready = idle;
    bus.arready = idle & ~bus.awvalid;
    bus.rvalid = state == RD;
    bus.rlast = (state == RD) & at_last;
    bus.wready = state == WR;
    bus.bvalid = state == WB;
  end
  // idx always points at the next word to read or the current word to write.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx <= '0;
      cnt <= '0;
      len <= '0;
      bus.rdata <= '0;
    end else if (ar_hs) begin
      idx <= ar_idx + 1'b1;
      cnt <= '0;
      len <= bus.arlen;
      bus.rdata <= mem[ar_idx];
    end else if (aw_hs) begin
      idx <= aw_idx;
      cnt <= '0;
      len <= bus.awlen;
    end else if ((r_hs && !at_last) || w_hs) begin
      idx <= idx + 1'b1;
      cnt <= cnt + 1'b1;
      if (r_hs) bus.rdata <= mem[idx];
    end
  always_ff @(posedge clk)
    if (w_hs)
      for (int i = 0; i < 4; i++)
        if (bus.wstrb[i]) mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
`ifdef AXI_SLV_CHECK_EN
  logic ar_pend, aw_pend, viol;
  logic [31:0] ar_addr_q, aw_addr_q;
  logic [7:0] ar_len_q, aw_len_q;
  assign viol = (w_hs && (bus.wlast != at_last))
    || (ar_pend && (!bus.arvalid || bus.araddr != ar_addr_q || bus.arlen != ar_len_q))
    || (aw_pend && (!bus.awvalid || bus.awaddr != aw_addr_q || bus.awlen != aw_len_q));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      proto_err <= 1'b0;
      ar_pend <= 1'b0;
      aw_pend <= 1'b0;
      ar_addr_q <= '0;
      aw_addr_q <= '0;
      ar_len_q <= '0;
      aw_len_q <= '0;
    end else begin
      proto_err <= proto_err | viol;
      ar_pend <= bus.arvalid & ~bus.arready;
      aw_pend <= bus.awvalid & ~bus.awready;
      ar_addr_q <= bus.araddr;
      aw_addr_q <= bus.awaddr;
      ar_len_q <= bus.arlen;
      aw_len_q <= bus.awlen;
    end
`else
  logic unused_wlast;
  assign unused_wlast = bus.wlast;
  assign proto_err = 1'b0;
`endif
endmodule

// File: tb/tb_d_axi_sram_responder.sv
// tb_d_axi_sram_responder: directed vectors and hand-written sequences for the AXI SRAM responder
module tb_d_axi_sram_responder;
  logic clk, rst, proto_err;
  int tests, fails;
  d_axi_sram_responder_if bus();
  d_axi_sram_responder #(.MEM_AW(12)) dut (.clk(clk), .rst(rst), .bus(bus), .proto_err(proto_err));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] init;
    logic [31:0] wdata;
    logic [3:0] strb;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[5];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] base, input logic [3:0] strb, input int last_at);
    @(negedge clk);
    bus.awvalid = 1'b1;
    bus.awaddr = addr;
    bus.awlen = len;
    bus.awsize = 3'd2;
    #1 chk("awready", 32'(bus.awready), 1);
    @(posedge clk);
    for (int k = 0; k <= int'(len); k++) begin
      @(negedge clk);
      bus.awvalid = 1'b0;
      bus.wvalid = 1'b1;
      bus.wdata = base + k;
      bus.wstrb = strb;
      bus.wlast = k == last_at;
      #1 chk("wready", 32'(bus.wready), 1);
      chk("bvalid_early", 32'(bus.bvalid), 0);
      @(posedge clk);
    end
    @(negedge clk);
    bus.wvalid = 1'b0;
    bus.wlast = 1'b0;
    bus.bready = 1'b1;
    #1 chk("bvalid", 32'(bus.bvalid), 1);
    chk("wready_wb", 32'(bus.wready), 0);
    @(posedge clk);
    @(negedge clk);
    bus.bready = 1'b0;
    #1 chk("bvalid_drop", 32'(bus.bvalid), 0);
    chk("awready_idle", 32'(bus.awready), 1);
  endtask
  task automatic ar_issue(input logic [31:0] addr, input logic [7:0] len);
    @(negedge clk);
    bus.arvalid = 1'b1;
    bus.araddr = addr;
    bus.arlen = len;
    bus.arsize = 3'd2;
    #1 chk("arready", 32'(bus.arready), 1);
    @(posedge clk);
  endtask
  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] base, input logic [3:0] pat);
    int k, c;
    ar_issue(addr, len);
    k = 0;
    c = 0;
    while (k <= int'(len) && c < 2000) begin
      @(negedge clk);
      bus.arvalid = 1'b0;
      bus.rready = pat[c[1:0]];
      #1 chk("rvalid", 32'(bus.rvalid), 1);
      chk("rdata", bus.rdata, base + k);
      chk("rlast", 32'(bus.rlast), 32'(k == int'(len)));
      if (bus.rready) k++;
      c++;
      @(posedge clk);
    end
    if (k <= int'(len)) chk("rd_timeout", k, 32'(len) + 1);
    @(negedge clk);
    bus.rready = 1'b0;
    #1 chk("rvalid_end", 32'(bus.rvalid), 0);
    chk("arready_end", 32'(bus.arready), 1);
  endtask
  initial begin
    tests = 0;
    fails = 0;
    vt[0] = '{32'h100, 32'hFFFF_FFFF, 32'h1122_3344, 4'b0101, 32'hFF22_FF44};
    vt[1] = '{32'h104, 32'h0000_0000, 32'hAABB_CCDD, 4'b1010, 32'hAA00_CC00};
    vt[2] = '{32'h108, 32'h1234_5678, 32'h0000_0000, 4'b0000, 32'h1234_5678};
    vt[3] = '{32'h10F, 32'h0000_0000, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF};
    vt[4] = '{32'h3FFC, 32'h5555_5555, 32'h0000_00AA, 4'b0001, 32'h5555_55AA};
    rst = 1'b1;
    {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready, bus.wlast} = '0;
    {bus.araddr, bus.awaddr, bus.wdata} = '0;
    {bus.arlen, bus.awlen, bus.arsize, bus.awsize, bus.wstrb} = '0;
    repeat (2) @(negedge clk);
    #1 chk("rst_arready", 32'(bus.arready), 0);
    chk("rst_awready", 32'(bus.awready), 0);
    chk("rst_rvalid", 32'(bus.rvalid), 0);
    chk("rst_rlast", 32'(bus.rlast), 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_wready", 32'(bus.wready), 0);
    chk("rst_bvalid", 32'(bus.bvalid), 0);
    chk("rst_proto_err", 32'(proto_err), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1 chk("idle_awready", 32'(bus.awready), 1);
    chk("idle_arready", 32'(bus.arready), 1);
    for (int i = 0; i < 5; i++) begin
      axi_write(vt[i].addr, 8'd0, vt[i].init, 4'hF, 0);
      axi_write(vt[i].addr, 8'd0, vt[i].wdata, vt[i].strb, 0);
      axi_read(vt[i].addr, 8'd0, vt[i].exp, 4'hF);
    end
    axi_write(32'h40, 8'd7, 32'hA0, 4'hF, 7);
    axi_read(32'h40, 8'd7, 32'hA0, 4'b1111);
    axi_read(32'h40, 8'd3, 32'hA0, 4'b1001);
    axi_write(32'h3FF8, 8'd0, 32'hB0, 4'hF, 0);
    axi_write(32'h3FFC, 8'd0, 32'hB1, 4'hF, 0);
    axi_write(32'h0, 8'd0, 32'hB2, 4'hF, 0);
    axi_write(32'h4, 8'd0, 32'hB3, 4'hF, 0);
    axi_read(32'h3FF8, 8'd3, 32'hB0, 4'b1111);
    axi_write(32'h800, 8'd255, 32'h1000, 4'hF, 255);
    axi_read(32'h800, 8'd255, 32'h1000, 4'b1111);
    @(negedge clk);
    bus.arvalid = 1'b1;
    bus.araddr = 32'h300;
    bus.arlen = 8'd0;
    bus.awvalid = 1'b1;
    bus.awaddr = 32'h300;
    bus.awlen = 8'd0;
    #1 chk("both_awready", 32'(bus.awready), 1);
    chk("both_arready", 32'(bus.arready), 0);
    @(posedge clk);
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b1;
    bus.wdata = 32'hCAFE_F00D;
    bus.wstrb = 4'hF;
    bus.wlast = 1'b1;
    #1 chk("both_wready", 32'(bus.wready), 1);
    chk("both_arready_wr", 32'(bus.arready), 0);
    @(posedge clk);
    @(negedge clk);
    bus.wvalid = 1'b0;
    bus.wlast = 1'b0;
    bus.bready = 1'b1;
    #1 chk("both_bvalid", 32'(bus.bvalid), 1);
    chk("both_arready_wb", 32'(bus.arready), 0);
    @(posedge clk);
    @(negedge clk);
    bus.bready = 1'b0;
    #1 chk("both_arready_idle", 32'(bus.arready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    #1 chk("both_rvalid", 32'(bus.rvalid), 1);
    chk("both_rdata", bus.rdata, 32'hCAFE_F00D);
    chk("both_rlast", 32'(bus.rlast), 1);
    @(posedge clk);
    @(negedge clk);
    bus.rready = 1'b0;
    #1 chk("both_rvalid_end", 32'(bus.rvalid), 0);
    axi_write(32'h400, 8'd3, 32'h70, 4'hF, 1);
`ifdef AXI_SLV_CHECK_EN
    chk("proto_err_set", 32'(proto_err), 1);
`else
    chk("proto_err_tied", 32'(proto_err), 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    #1 chk("proto_err_clr", 32'(proto_err), 0);
    @(negedge clk);
    rst = 1'b0;
    axi_read(32'h400, 8'd3, 32'h70, 4'b1111);
    axi_write(32'h200, 8'd7, 32'h5000, 4'hF, 7);
    ar_issue(32'h200, 8'd7);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.arvalid = 1'b0;
      bus.rready = 1'b1;
      #1 chk("mid_rdata", bus.rdata, 32'h5000 + k);
      @(posedge clk);
    end
    @(negedge clk);
    rst = 1'b1;
    #1 chk("mid_rvalid", 32'(bus.rvalid), 0);
    chk("mid_rlast", 32'(bus.rlast), 0);
    chk("mid_rdata_rst", bus.rdata, 0);
    chk("mid_arready_rst", 32'(bus.arready), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.rready = 1'b0;
    #1 chk("mid_arready_rel", 32'(bus.arready), 1);
    chk("mid_rvalid_rel", 32'(bus.rvalid), 0);
    axi_read(32'h204, 8'd0, 32'h5001, 4'hF);
    chk("proto_err_final", 32'(proto_err), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/d_axi_sram_responder.md
# d_axi_sram_responder

AXI4-subset memory responder answering the data-side master port (the AR/R/AW/W/B signal set the data arbiter drives). Services one transaction at a time: INCR read bursts for cache refills and uncached single reads, INCR write bursts for cache write-backs and byte-strobed uncached stores, backed by an internal word-addressed SRAM array. Used as the data-memory model in simulation and as on-chip scratch RAM in synthesis.

## Interface
- MEM_AW, 12: log2 of SRAM depth in 32-bit words; default 4096 words / 16 KiB.
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset; asynchronous, active-high.
- araddr  in  32  read burst start byte address.
- arlen  in  8  read beats minus one.
- arsize  in  3  beat size; accepted, does not change addressing.
- arvalid / arready  in / out  1  read address handshake.
- rdata  out  32  read beat data, full aligned word.
- rlast  out  1  high on final read beat.
- rvalid / rready  out / in  1  read data handshake.
- awaddr  in  32  write burst start byte address.
- awlen  in  8  write beats minus one.
- awsize  in  3  accepted, ignored; wstrb governs bytes.
- awvalid / awready  in / out  1  write address handshake.
- wdata  in  32  write beat data.
- wstrb  in  4  byte enables; bit i writes wdata[8i+7:8i].
- wlast  in  1  master's last-beat marker.
- wvalid / wready  in / out  1  write data handshake.
- bvalid / bready  out / in  1  write response handshake.
- proto_err  out  1  sticky protocol-violation flag.

## Operation
- FSM states: IDLE, RD, WR, WB.
- IDLE: awready=1; arready = ~awvalid. Simultaneous arvalid and awvalid: write wins (write-back before refill); read accepted on a later IDLE cycle.
- AR handshake -> RD: latch word index araddr[MEM_AW+1:2] and beat count arlen. araddr[1:0] ignored.
- RD: beat k returns mem[(start+k) mod 2^MEM_AW]; index wraps silently at array top. rlast=1 on beat arlen. After last R handshake -> IDLE.
- AW handshake -> WR: latch index and awlen. wready=1 throughout WR, 0 elsewhere; W beats presented in IDLE are not accepted.
- WR: each W handshake writes bytes selected by wstrb at current index, then increments index; wstrb=0 writes nothing but consumes a beat. Internal beat counter is authoritative: after beat awlen -> WB regardless of wlast.
- WB: bvalid=1 until bready; on B handshake -> IDLE.
- Single outstanding transaction; no read/write overlap, so no memory hazard.
- SRAM contents not reset; uninitialised words read as X in simulation.

## Timing
- Reset values: arready=0, awready=0, rvalid=0, rlast=0, rdata=0, wready=0, bvalid=0, proto_err=0; state IDLE. arready/awready rise in the first IDLE cycle after rst falls.
- Read latency: AR handshake in cycle N -> first rvalid in cycle N+1 (one-cycle synchronous SRAM read). With rready held high, beats are back-to-back, one per cycle.
- rready low: rvalid, rdata, rlast held stable until handshake.
- Write: last W handshake in cycle M -> bvalid in cycle M+1. bready may already be high; handshake then completes in M+1.
- Earliest new address accept: cycle after last R or B handshake.
- Reset mid-burst: immediate abort, outputs to reset values, remaining beats never issued; words already written stay written.
- arlen=0 / awlen=0: single beat with rlast=1 / single write then WB.
- arlen=255: 256 beats; beat counter is 8 bits, no overflow.

## Configuration
- AXI_SLV_CHECK_EN defined: protocol checker compiled in; proto_err set and held (until rst) when wlast disagrees with beat count (high before beat awlen or low on beat awlen), when arvalid/awvalid drop before handshake, or when araddr/awaddr/arlen/awlen change while valid and not ready.
- Undefined: checker absent, proto_err tied 0, no other behaviour change.

## Test plan
- Preload mem[0x10..0x17]=0xA0..0xA7; read araddr=0x40, arlen=7, rready=1 -> rvalid from N+1 for 8 consecutive cycles, rdata 0xA0..0xA7, rlast only on 0xA7.
- Write awaddr=0x100, awlen=0, wdata=0x11223344, wstrb=0101 onto word 0xFFFFFFFF -> bvalid cycle after W; reading 0x100 returns 0xFF22FF44.
- Same-cycle arvalid and awvalid -> awready handshake first, arready=0 that cycle; read served after B handshake, returning the newly written data.
- 4-beat read with rready toggling 1,0,0,1,... -> each beat's rdata/rlast stable across stall cycles; exactly 4 handshakes; back to IDLE.
- Read araddr=(2^MEM_AW-2)*4, arlen=3 -> beats from indices 4094, 4095, 0, 1.
- With AXI_SLV_CHECK_EN, awlen=3 and wlast=1 on beat 1 -> proto_err=1, 4 beats still consumed, bvalid after beat 3; rst clears proto_err. Assert rst during beat 2 of an 8-beat read -> rvalid=0 immediately, arready=1 after release.
